// File: rtl/axis_labcontrol_master.sv
// AXI-Stream slave driving one timed LabControl write cycle (DIOA..DIOD) per accepted beat.
// Optional build macro AXIS_LABCONTROL_MASTER_IDLE_CLEAR_EN clears the bus on return to IDLE.
module axis_labcontrol_master #(
  parameter int S_AXIS_DATA_WIDTH = 32,
  parameter int SETUP_CYCLES      = 4,
  parameter int STROBE_CYCLES     = 4,
  parameter int HOLD_CYCLES       = 4,
  parameter int CNT_WIDTH         = 8
) (
  input  logic                         s_axis_aclk,
  input  logic                         s_axis_aresetn,
  input  logic [S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [7:0]                   DIOA,
  output logic [7:0]                   DIOB,
  output logic [7:0]                   DIOC,
  output logic [7:0]                   DIOD,
  output logic                         busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] SETUP_LOAD  = CNT_WIDTH'(SETUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STROBE_LOAD = CNT_WIDTH'(STROBE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD   = CNT_WIDTH'(HOLD_CYCLES - 1);

  state_t               state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [7:0]           data_hi_r;
  logic [7:0]           data_lo_r;
  logic [7:0]           addr_r;
  logic [2:0]           sub_r;
  logic                 strobe_r;
  logic                 busy_r;
  logic                 ready_en_r;
  logic                 accept_s;
  logic                 cnt_done_s;

  // ready_en_r is low while reset is held, so tready drops asynchronously with reset
  assign s_axis_tready = (state_r == ST_IDLE) & ready_en_r;
  assign accept_s      = s_axis_tvalid & s_axis_tready;
  assign cnt_done_s    = (cnt_r == CNT_ZERO);

  assign DIOA = data_hi_r;
  assign DIOB = data_lo_r;
  assign DIOC = addr_r;
  assign DIOD = {3'b000, sub_r, 1'b0, strobe_r};
  assign busy = busy_r;

  generate
    if (S_AXIS_DATA_WIDTH > 27) begin : g_unused
      logic unused_tdata_s;
      assign unused_tdata_s = ^s_axis_tdata[S_AXIS_DATA_WIDTH-1:27];
    end
  endgenerate

  // Write-cycle sequencer: latches the beat, then times setup, strobe and hold phases
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      data_hi_r  <= 8'h00;
      data_lo_r  <= 8'h00;
      addr_r     <= 8'h00;
      sub_r      <= 3'b000;
      strobe_r   <= 1'b0;
      busy_r     <= 1'b0;
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          strobe_r <= 1'b0;
          if (accept_s) begin
            data_hi_r <= s_axis_tdata[15:8];
            data_lo_r <= s_axis_tdata[7:0];
            addr_r    <= s_axis_tdata[23:16];
            sub_r     <= s_axis_tdata[26:24];
            cnt_r     <= SETUP_LOAD;
            busy_r    <= 1'b1;
            state_r   <= ST_SETUP;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (cnt_done_s) begin
            strobe_r <= 1'b1;
            cnt_r    <= STROBE_LOAD;
            state_r  <= ST_STROBE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_STROBE: begin
          if (cnt_done_s) begin
            strobe_r <= 1'b0;
            cnt_r    <= HOLD_LOAD;
            state_r  <= ST_HOLD;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt_done_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
`ifdef AXIS_LABCONTROL_MASTER_IDLE_CLEAR_EN
            data_hi_r <= 8'h00;
            data_lo_r <= 8'h00;
            addr_r    <= 8'h00;
            sub_r     <= 3'b000;
`else
            data_hi_r <= data_hi_r;
            data_lo_r <= data_lo_r;
            addr_r    <= addr_r;
            sub_r     <= sub_r;
`endif
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          strobe_r <= 1'b0;
          busy_r   <= 1'b0;
          cnt_r    <= CNT_ZERO;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_labcontrol_master.sv
// Scoreboard bench for axis_labcontrol_master: default-timing instance plus a 1/1/1 timing instance.
module tb_axis_labcontrol_master;

  localparam int SETUP  = 4;
  localparam int STROBE = 4;
  localparam int HOLD   = 4;
  localparam int PERIOD = SETUP + STROBE + HOLD + 1;

  typedef struct {
    logic [31:0] data;
    int          e0;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] tdata, f_tdata;
  logic        tvalid, f_tvalid;
  logic        tready, f_tready;
  logic [7:0]  dioa, diob, dioc, diod, f_dioa, f_diob, f_dioc, f_diod;
  logic        busy, f_busy;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  axis_labcontrol_master dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .DIOA(dioa), .DIOB(diob), .DIOC(dioc), .DIOD(diod), .busy(busy)
  );

  axis_labcontrol_master #(
    .S_AXIS_DATA_WIDTH(32), .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .CNT_WIDTH(8)
  ) dut_fast (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis_tdata(f_tdata),
    .s_axis_tvalid(f_tvalid), .s_axis_tready(f_tready),
    .DIOA(f_dioa), .DIOB(f_diob), .DIOC(f_dioc), .DIOD(f_diod), .busy(f_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] d, input logic strobe);
    return {d[15:8], d[7:0], d[23:16], 3'b000, d[26:24], 1'b0, strobe};
  endfunction

  function automatic logic [31:0] exp_idle(input logic [31:0] d);
`ifdef AXIS_LABCONTROL_MASTER_IDLE_CLEAR_EN
    return 32'h0000_0000 & d;
`else
    return exp_word(d, 1'b0);
`endif
  endfunction

  // Drive one beat from a negedge; returns the acceptance edge index and queues the expectation
  task automatic send(input logic [31:0] d, output int e0);
    int n = 0;
    tdata  = d;
    tvalid = 1'b1;
    while (!tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tready) begin
      check_val("accept_timeout", 64'd0, 64'd1);
      e0 = -1000;
    end else begin
      e0 = cyc + 1;
      sb_q.push_back('{d, e0});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int at);
    int n = 0;
    @(negedge clk);
    while (!tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tready) check_val("ready_timeout", 64'd0, 64'd1);
    at = cyc;
  endtask

  // Monitor: pops an expectation at each strobe rise and checks pulse timing and bus contents
  initial begin
    logic prev_s = 1'b0;
    logic active = 1'b0;
    int   rise_cyc = 0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_s = 1'b0;
        active = 1'b0;
      end else begin
        if (diod[0] && !prev_s) begin
          if (sb_q.size() == 0) begin
            check_val("sb_underflow", 64'd1, 64'd0);
          end else begin
            cur      = sb_q.pop_front();
            active   = 1'b1;
            rise_cyc = cyc;
            check_val("rise_dio", {dioa, diob, dioc, diod}, exp_word(cur.data, 1'b1));
            check_val("rise_time", cyc, cur.e0 + SETUP);
            check_val("rise_busy", busy, 1'b1);
          end
        end
        if (!diod[0] && prev_s && active) begin
          check_val("fall_dio", {dioa, diob, dioc, diod}, exp_word(cur.data, 1'b0));
          check_val("fall_time", cyc, rise_cyc + STROBE);
        end
        if (active && !busy) begin
          check_val("idle_dio", {dioa, diob, dioc, diod}, exp_idle(cur.data));
          check_val("idle_time", cyc, rise_cyc + STROBE + HOLD);
          active = 1'b0;
        end
        prev_s = diod[0];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, e2, e3, at;
    logic [31:0] fb1, fb2;
    rst_n = 1'b1; tdata = 32'h0; tvalid = 1'b0; f_tdata = 32'h0; f_tvalid = 1'b0;
    #2 rst_n = 1'b0;

    // Reset state and release
    repeat (3) @(negedge clk);
    check_val("rst_tready", tready, 1'b0);
    check_val("rst_dio", {dioa, diob, dioc, diod}, 32'h0);
    check_val("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    #1 check_val("rel_tready_early", tready, 1'b0);
    @(negedge clk);
    check_val("rel_tready", tready, 1'b1);
    repeat (3) @(negedge clk);
    check_val("rel_tready_stay", tready, 1'b1);
    check_val("rel_dio", {dioa, diob, dioc, diod}, 32'h0);
    check_val("rel_busy", busy, 1'b0);

    // Fast instance: 1/1/1 timing, period 4, tdata toggled while not ready
    fb1 = 32'h0155_C33C;
    fb2 = 32'h0642_7E81;
    check_val("fast_ready", f_tready, 1'b1);
    f_tdata = fb1; f_tvalid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      case (k)
        0, 1, 2: check_val("fast_b1", {f_dioa, f_diob, f_dioc, f_diod}, exp_word(fb1, k == 1));
        3:       check_val("fast_idle", {f_dioa, f_diob, f_dioc, f_diod}, exp_idle(fb1));
        default: check_val("fast_b2", {f_dioa, f_diob, f_dioc, f_diod}, exp_word(fb2, k == 5));
      endcase
      check_val("fast_busy", f_busy, k != 3);
      check_val("fast_tready", f_tready, k == 3);
      if (k < 2 || k == 4) f_tdata = $urandom;
      else if (k == 2) f_tdata = fb2;
      else if (k == 5) f_tvalid = 1'b0;
    end
    repeat (4) @(negedge clk);
    check_val("fast_end", {f_dioa, f_diob, f_dioc, f_diod}, exp_idle(fb2));

    // Single default beat
    @(negedge clk);
    send(32'h03FF_A55A, e0);
    tvalid = 1'b0;
    @(negedge clk);
    check_val("e0_dio", {dioa, diob, dioc, diod}, 32'hA55A_FF0C);
    tdata = 32'h07FF_FFFF;
    wait_ready(at);
    check_val("ready_back", at - e0, SETUP + STROBE + HOLD);

    // Back-to-back with tvalid held
    @(negedge clk);
    send(32'h0201_1111, e1);
    send(32'h0502_2222, e2);
    send(32'h0703_3333, e3);
    tvalid = 1'b0;
    check_val("b2b_gap1", e2 - e1, PERIOD);
    check_val("b2b_gap2", e3 - e2, PERIOD);
    wait_ready(at);

    // Reset in the middle of the strobe phase
    @(negedge clk);
    send(32'h04AB_CDEF, e0);
    tvalid = 1'b0;
    while (cyc < e0 + 5) @(negedge clk);
    check_val("mid_strobe", diod[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_dio", {dioa, diob, dioc, diod}, 32'h0);
    check_val("async_busy", busy, 1'b0);
    check_val("async_tready", tready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rerel_tready", tready, 1'b1);

    // Full cycle after reset; bus contents once idle depend on the clear build option
    send(32'h0010_1234, e0);
    tvalid = 1'b0;
    wait_ready(at);
    check_val("post_rst_ready", at - e0, SETUP + STROBE + HOLD);
    repeat (3) @(negedge clk);
    check_val("idle_hold", {dioa, diob, dioc, diod}, exp_idle(32'h0010_1234));
    check_val("sb_drain", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
